shift_sequencer: RTL and testbench

Parametrised, registered multi-cycle shifter/rotator. It is the sequential successor to the 4-bit one-hot-controlled combinational shifters. A start pulse loads a WIDTH-bit operand, a mode and a shift amount. The block then shifts one position per clock, reports the last bit shifted out, and signals completion with a done pulse. It sits between operand registers and any consumer that needs variable shifts or serial streaming without a wide barrel network.

---
 rtl/shift_sequencer.sv | 136 +++++++++++++
 tb/tb_shift_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Registered multi-cycle shifter/rotator: one single-bit step per clock,
// carry holds the last bit shifted out, done pulses one cycle on completion.
//
// state | meaning
// IDLE  | waiting for start; dout/carry hold the last result
// SHIFT | applying one step per edge until count reaches zero
// DONE  | result valid, done pulse; returns to IDLE on the next edge
module shift_sequencer #(
    parameter int WIDTH   = 4,
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         mode,
    input  logic [SHAMT_W-1:0] amt,
    input  logic [WIDTH-1:0]   din,
    input  logic               ser_in,
    output logic [WIDTH-1:0]   dout,
    output logic               carry,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] MODE_LSL = 3'd1;
    localparam logic [2:0] MODE_LSR = 3'd2;
    localparam logic [2:0] MODE_ASR = 3'd3;
    localparam logic [2:0] MODE_ROL = 3'd4;
    localparam logic [2:0] MODE_ROR = 3'd5;

    state_t             state;
    state_t             state_nxt;
    logic [SHAMT_W-1:0] count;
    logic [2:0]         mode_q;
    logic [WIDTH-1:0]   step_data;
    logic               step_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (count == SHAMT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // One single-bit step of the latched operation; HOLD and reserved modes clear carry.
    always_comb begin
        step_data  = dout;
        step_carry = 1'b0;
        case (mode_q)
            MODE_LSL: begin
                step_data  = {dout[WIDTH-2:0], ser_in};
                step_carry = dout[WIDTH-1];
            end
            MODE_LSR: begin
                step_data  = {ser_in, dout[WIDTH-1:1]};
                step_carry = dout[0];
            end
            MODE_ASR: begin
                step_data  = {dout[WIDTH-1], dout[WIDTH-1:1]};
                step_carry = dout[0];
            end
            MODE_ROL: begin
                step_data  = {dout[WIDTH-2:0], dout[WIDTH-1]};
                step_carry = dout[WIDTH-1];
            end
            MODE_ROR: begin
                step_data  = {dout[0], dout[WIDTH-1:1]};
                step_carry = dout[0];
            end
            default: begin
                step_data  = dout;
                step_carry = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout   <= '0;
            carry  <= 1'b0;
            count  <= '0;
            mode_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dout   <= din;
                        carry  <= 1'b0;
                        mode_q <= mode;
                        count  <= amt;
                    end
                end
                SHIFT: begin
                    dout  <= step_data;
                    carry <= step_carry;
                    count <= count - SHAMT_W'(1);
                end
                default: begin
                    dout  <= dout;
                    carry <= carry;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer (WIDTH=4): expected results come from a
// bit-level reference model and are popped when the done pulse is seen.
module tb_shift_sequencer;

    localparam int WIDTH   = 4;
    localparam int SHAMT_W = 3;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [2:0]         mode;
    logic [SHAMT_W-1:0] amt;
    logic [WIDTH-1:0]   din;
    logic               ser_in;
    logic [WIDTH-1:0]   dout;
    logic               carry;
    logic               busy;
    logic               done;

    typedef struct {
        logic [3:0] d;
        logic       c;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] trace_q[$];
    int         total = 0;
    int         bad = 0;

    shift_sequencer #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mode   (mode),
        .amt    (amt),
        .din    (din),
        .ser_in (ser_in),
        .dout   (dout),
        .carry  (carry),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: apply 'a' single-bit steps to d, returns {carry, data}.
    function automatic logic [4:0] model(input logic [2:0] m, input int a,
                                         input logic [3:0] d, input logic si);
        logic [3:0] v;
        logic       c;
        v = d;
        c = 1'b0;
        for (int i = 0; i < a; i++) begin
            case (m)
                3'd1: begin c = v[3]; v = {v[2:0], si};   end
                3'd2: begin c = v[0]; v = {si, v[3:1]};   end
                3'd3: begin c = v[0]; v = {v[3], v[3:1]}; end
                3'd4: begin c = v[3]; v = {v[2:0], v[3]}; end
                3'd5: begin c = v[0]; v = {v[0], v[3:1]}; end
                default: c = 1'b0;
            endcase
        end
        return {c, v};
    endfunction

    // Issue one operation; optionally re-pulse start (din=1111) while busy.
    task automatic run_op(input logic [2:0] m, input int a, input logic [3:0] d,
                          input logic si, input logic poke, input string tag);
        exp_t       e;
        logic [4:0] r;
        int         busy_cnt;
        int         done_cnt;
        logic [3:0] got_d;
        logic       got_c;
        r     = model(m, a, d, si);
        e.d   = r[3:0];
        e.c   = r[4];
        e.cyc = a + 1;
        exp_q.push_back(e);
        trace_q.delete();
        busy_cnt = 0;
        done_cnt = 0;
        got_d    = '0;
        got_c    = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        mode   = m;
        amt    = SHAMT_W'(a);
        din    = d;
        ser_in = si;
        @(negedge clk);
        start = 1'b0;
        din   = 4'h0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            busy_cnt++;
            trace_q.push_back(dout);
            if (done) begin
                done_cnt++;
                got_d = dout;
                got_c = carry;
            end
            if (poke) begin
                start = 1'b1;
                din   = 4'hF;
            end
            @(negedge clk);
            start = 1'b0;
        end
        e = exp_q.pop_front();
        chk({tag, "_dout"}, 32'(got_d), 32'(e.d));
        chk({tag, "_carry"}, 32'(got_c), 32'(e.c));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(e.cyc));
        chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        chk({tag, "_quiet_after"}, 32'(done_cnt), 32'd1);
        chk({tag, "_hold_dout"}, 32'(dout), 32'(e.d));
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        mode   = 3'd0;
        amt    = '0;
        din    = '0;
        ser_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(3'd1, 3, 4'b0001, 1'b0, 1'b0, "lsl3");
        run_op(3'd3, 2, 4'b1000, 1'b0, 1'b0, "asr2");
        run_op(3'd5, 1, 4'b1011, 1'b0, 1'b0, "ror1");
        run_op(3'd4, 4, 4'b0110, 1'b0, 1'b0, "rol4");
        chk("rol4_trace_len", 32'(trace_q.size()), 32'd5);
        if (trace_q.size() == 5) begin
            chk("rol4_step1", 32'(trace_q[1]), 32'(4'b1100));
            chk("rol4_step2", 32'(trace_q[2]), 32'(4'b1001));
            chk("rol4_step3", 32'(trace_q[3]), 32'(4'b0011));
        end
        run_op(3'd2, 2, 4'b0000, 1'b1, 1'b0, "lsr2_fill");
        run_op(3'd1, 0, 4'b1010, 1'b1, 1'b0, "amt0_lsl");
        run_op(3'd4, 0, 4'b1010, 1'b0, 1'b0, "amt0_rol");
        run_op(3'd1, 3, 4'b0001, 1'b0, 1'b1, "lsl3_ignore");
        run_op(3'd1, 6, 4'b0000, 1'b1, 1'b0, "lsl6_fill");
        run_op(3'd3, 7, 4'b1000, 1'b0, 1'b0, "asr7");
        run_op(3'd5, 4, 4'b1001, 1'b0, 1'b0, "ror4");
        run_op(3'd0, 3, 4'b0101, 1'b1, 1'b0, "hold3");
        run_op(3'd6, 2, 4'b1100, 1'b1, 1'b0, "rsvd6");

        // Reset between E1 and E2 of an amt=3 ROL.
        @(negedge clk);
        start = 1'b1;
        mode  = 3'd4;
        amt   = 3'd3;
        din   = 4'b0110;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_dout", 32'(dout), 32'd0);
        chk("midrst_carry", 32'(carry), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_busy", 32'(busy), 32'd0);
        run_op(3'd4, 3, 4'b0110, 1'b0, 1'b0, "postrst_rol3");

        for (int k = 0; k < 16; k++) begin
            run_op(3'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
